// File: rtl/sa_blkbox_pattern_src.sv
// Programmable valid/ready pattern source (zero/constant/increment/LFSR) replacing SA tie-offs.
// Optional stall counter port enabled by defining SA_PATSRC_STALL_CNT_EN.
module sa_blkbox_pattern_src #(
  parameter int unsigned DW    = 32,
  parameter int unsigned CNT_W = 16,
  parameter logic [31:0] POLY  = 32'h80200003
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic [1:0]       cfg_mode,
  input  logic [DW-1:0]    cfg_const,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             dout_pvld,
  input  logic             dout_prdy,
  output logic [DW-1:0]    dout_pd
`ifdef SA_PATSRC_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  localparam logic [DW-1:0] POLY_MASK = DW'(POLY);

  localparam logic [1:0] MODE_ZERO  = 2'd0;
  localparam logic [1:0] MODE_CONST = 2'd1;
  localparam logic [1:0] MODE_INCR  = 2'd2;
  localparam logic [1:0] MODE_LFSR  = 2'd3;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  state_t           state;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] remaining;
  logic [DW-1:0]    load_val;
  logic [DW-1:0]    pat_next;
  logic             accept;

  assign accept = dout_pvld && dout_prdy;

  // Seed for a new run; LFSR seed is forced odd so it can never lock up at zero.
  always_comb begin
    load_val = '0;
    case (cfg_mode)
      MODE_CONST, MODE_INCR: load_val = cfg_const;
      MODE_LFSR:             load_val = cfg_const | DW'(1);
      default:               load_val = '0;
    endcase
  end

  always_comb begin
    pat_next = dout_pd;
    case (mode_q)
      MODE_INCR: pat_next = dout_pd + DW'(1);
      MODE_LFSR: pat_next = (dout_pd >> 1) ^ (dout_pd[0] ? POLY_MASK : '0);
      default:   pat_next = dout_pd;
    endcase
  end

  // dout_pd doubles as the pattern register and is zero whenever not in RUN.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state     <= IDLE;
      mode_q    <= MODE_ZERO;
      remaining <= '0;
      dout_pd   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dout_pvld <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_q    <= cfg_mode;
            remaining <= cfg_len;
            if (cfg_len == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state     <= RUN;
              busy      <= 1'b1;
              dout_pvld <= 1'b1;
              dout_pd   <= load_val;
            end
          end
        end
        RUN: begin
          if (accept) begin
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              state     <= FIN;
              busy      <= 1'b0;
              dout_pvld <= 1'b0;
              dout_pd   <= '0;
              done      <= 1'b1;
            end else begin
              dout_pd <= pat_next;
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SA_PATSRC_STALL_CNT_EN
  // Saturating count of back-pressured cycles in the current run.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      stall_cnt <= '0;
    end else if (state == IDLE && start) begin
      stall_cnt <= '0;
    end else if (dout_pvld && !dout_prdy && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_sa_blkbox_pattern_src.sv
// Scoreboard bench for sa_blkbox_pattern_src: directed runs, a monitor pops expected beats.
module tb_sa_blkbox_pattern_src;

  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             rst;
  logic [1:0]       cfg_mode;
  logic [DW-1:0]    cfg_const;
  logic [CNT_W-1:0] cfg_len;
  logic             start;
  logic             busy;
  logic             done;
  logic             pvld;
  logic             prdy;
  logic [DW-1:0]    pd;
`ifdef SA_PATSRC_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];

  sa_blkbox_pattern_src #(.DW(DW), .CNT_W(CNT_W), .POLY(32'h80200003)) dut (
    .nvdla_core_clk(clk),
    .nvdla_core_rst(rst),
    .cfg_mode(cfg_mode),
    .cfg_const(cfg_const),
    .cfg_len(cfg_len),
    .start(start),
    .busy(busy),
    .done(done),
    .dout_pvld(pvld),
    .dout_prdy(prdy),
    .dout_pd(pd)
`ifdef SA_PATSRC_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [1:0] m, input logic [DW-1:0] c, input logic [CNT_W-1:0] l);
    cfg_mode  = m;
    cfg_const = c;
    cfg_len   = l;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Drive prdy (steady 1 or toggling from 1) until done is seen, with a cycle budget.
  task automatic run_until_done(input int budget, input bit toggle);
    bit r;
    bit seen;
    r = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      prdy = r;
      tick();
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (toggle) r = !r;
    end
    prdy = 1'b1;
    check("done_within_budget", 64'(seen), 64'd1);
  endtask

  // Monitor: pops expected beats on handshake, checks hold-under-stall and idle tie-off.
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_pd   = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_hold) begin
        check("stall_pvld_hold", 64'(pvld), 64'd1);
        check("stall_pd_hold", 64'(pd), 64'(prev_pd));
      end
      if (pvld === 1'b1 && prdy === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL beat_unexpected: got %h expected none", pd);
        end else begin
          check("beat_data", 64'(pd), 64'(exp_q.pop_front()));
        end
      end else if (pvld === 1'b0) begin
        check("idle_pd_zero", 64'(pd), 64'd0);
      end
    end
    prev_hold = (pvld === 1'b1) && (prdy === 1'b0) && !rst;
    prev_pd   = pd;
  end

  initial begin
    rst = 1'b1; prdy = 1'b1; start = 1'b0;
    cfg_mode = '0; cfg_const = '0; cfg_len = '0;
    tick(); tick();
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      check("idle_pvld", 64'(pvld), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_done", 64'(done), 64'd0);
      tick();
    end

    // Constant mode, full throughput
    repeat (4) exp_q.push_back(32'hA5A5_0001);
    start_run(2'd1, 32'hA5A5_0001, 16'd4);
    for (int i = 0; i < 4; i++) begin
      check("const_busy", 64'(busy), 64'd1);
      check("const_pvld", 64'(pvld), 64'd1);
      check("const_done_low", 64'(done), 64'd0);
      tick();
    end
    check("const_done", 64'(done), 64'd1);
    check("const_busy_fin", 64'(busy), 64'd0);
    check("const_pvld_fin", 64'(pvld), 64'd0);
    tick();
    check("const_done_pulse", 64'(done), 64'd0);

    // Increment with wrap, back-pressure toggling
    exp_q.push_back(32'hFFFF_FFFE);
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_0000);
    start_run(2'd2, 32'hFFFF_FFFE, 16'd3);
    run_until_done(20, 1'b1);
`ifdef SA_PATSRC_STALL_CNT_EN
    check("stall_cnt_run", 64'(stall_cnt), 64'd2);
    tick();
    check("stall_cnt_hold", 64'(stall_cnt), 64'd2);
`else
    tick();
`endif

    // LFSR with zero seed forced to 1
    exp_q.push_back(32'h0000_0001);
    exp_q.push_back(32'h8020_0003);
    exp_q.push_back(32'hC030_0002);
    start_run(2'd3, 32'h0, 16'd3);
    run_until_done(20, 1'b0);
    tick();

    // Zero length: no beats, immediate done
    start_run(2'd1, 32'h33, 16'd0);
    check("len0_done", 64'(done), 64'd1);
    check("len0_busy", 64'(busy), 64'd0);
    check("len0_pvld", 64'(pvld), 64'd0);
    tick();
    check("len0_done_pulse", 64'(done), 64'd0);

    // Start while busy and start on done cycle are ignored
    exp_q.push_back(32'h11);
    exp_q.push_back(32'h11);
    prdy = 1'b0;
    start_run(2'd1, 32'h11, 16'd2);
    check("busy_run", 64'(busy), 64'd1);
    start_run(2'd1, 32'h22, 16'd5);
    check("ignored_pd", 64'(pd), 64'h11);
    run_until_done(20, 1'b0);
    start_run(2'd1, 32'h44, 16'd5);
    check("done_start_busy", 64'(busy), 64'd0);
    check("done_start_pvld", 64'(pvld), 64'd0);
    repeat (3) tick();
    check("after_ignore_pvld", 64'(pvld), 64'd0);

    // Reset mid-run aborts without done
    exp_q.push_back(32'd100);
    exp_q.push_back(32'd101);
    start_run(2'd2, 32'd100, 16'd8);
    tick(); tick();
    rst = 1'b1; prdy = 1'b0;
    tick();
    check("abort_pvld", 64'(pvld), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_pd", 64'(pd), 64'd0);
`ifdef SA_PATSRC_STALL_CNT_EN
    check("abort_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    rst = 1'b0; prdy = 1'b1;
    tick();
    check("abort_no_done", 64'(done), 64'd0);
    exp_q.push_back(32'h5);
    start_run(2'd1, 32'h5, 16'd1);
    check("fresh_pvld", 64'(pvld), 64'd1);
    tick();
    check("fresh_done", 64'(done), 64'd1);
    repeat (2) tick();

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
